// File: rtl/reduce_pkg.sv
// reduce_pkg: shared defaults, modulus constant and FSM state type for reduce_seq
package reduce_pkg;
    localparam int N_DEF = 255;
    localparam int C_DEF = 19;
    localparam int CW_DEF = 5;
    localparam logic [N_DEF-1:0] P = '0 - N_DEF'(C_DEF);
    typedef enum logic [2:0] {IDLE, FOLD1, FOLD2, SUB, DONE} reduce_state_t;
endpackage

// File: rtl/mod_fold.sv
// mod_fold: one pseudo-Mersenne fold step, sum = hi*C + lo
module mod_fold #(
    parameter int N = 255,
    parameter int C = 19,
    parameter int CW = 5,
    parameter int HW = 255,
    localparam int OW = ((N > HW + CW) ? N : HW + CW) + 1
) (
    input  logic [HW-1:0] hi,
    input  logic [N-1:0]  lo,
    output logic [OW-1:0] sum
);
    assign sum = OW'(hi) * OW'(C) + OW'(lo);
endmodule

// File: rtl/reduce_seq.sv
// reduce_seq: sequential r = n mod (2^N - C) with valid/ready on both sides
module reduce_seq import reduce_pkg::*; #(
    parameter int N = N_DEF,
    parameter int C = C_DEF,
    parameter int CW = CW_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2*N-1:0] n,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] r
);
    localparam logic [N-1:0] PM = '0 - N'(C);
    localparam logic [N:0] LIM = ((N+1)'(1) << N) - (N+1)'(2 * C);
    localparam logic [N:0] TH = (N+1)'(1) << (2 * CW + 1);
    if (C < 1 || C >= (1 << CW) || TH >= LIM) begin : g_bad
        $error("reduce_seq: unsupported N/C/CW combination");
    end
    reduce_state_t state, state_n;
    logic [2*N-1:0] acc;
    logic [N+CW:0] s1;
    logic [N:0] s2;
    logic ge;
    mod_fold #(.N(N), .C(C), .CW(CW), .HW(N)) u_fold1 (.hi(acc[2*N-1:N]), .lo(acc[N-1:0]), .sum(s1));
    mod_fold #(.N(N), .C(C), .CW(CW), .HW(CW+1)) u_fold2 (.hi(acc[N+CW:N]), .lo(acc[N-1:0]), .sum(s2));
    assign in_ready = state == IDLE || (state == DONE && out_ready);
    assign out_valid = state == DONE;
    assign ge = acc[N:0] >= {1'b0, PM};
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? FOLD1 : IDLE;
            FOLD1:   state_n = FOLD2;
            FOLD2:   state_n = SUB;
            SUB:     state_n = DONE;
            DONE:    state_n = out_ready ? (in_valid ? FOLD1 : IDLE) : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // After FOLD2 the value is below 2p, so one subtract fully reduces it
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            r <= '0;
        end else if (in_valid && in_ready) acc <= n;
        else if (state == FOLD1) acc <= (2*N)'(s1);
        else if (state == FOLD2) acc <= (2*N)'(s2);
        else if (state == SUB) r <= ge ? N'(acc[N:0] - {1'b0, PM}) : acc[N-1:0];
    end
endmodule

// File: tb/tb_reduce_seq.sv
// tb_reduce_seq: vector, corner-sequence and random checks of reduce_seq at N=255 and N=16
module tb_reduce_seq;
    localparam logic [254:0] BP = {255{1'b1}} - 255'd18;
    logic clk, rst;
    logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [509:0] b_n;
    logic [254:0] b_r;
    logic s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [31:0] s_n;
    logic [15:0] s_r;
    int total = 0, bad = 0;
    typedef struct { logic [509:0] n; logic [254:0] r; } bvec_t;
    typedef struct { logic [31:0] n; logic [15:0] r; } svec_t;
    bvec_t bt[7];
    svec_t st[4];

    reduce_seq u_big (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .n(b_n),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .r(b_r)
    );
    reduce_seq #(.N(16), .C(15), .CW(4)) u_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .n(s_n),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .r(s_r)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    initial begin
        #900000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [254:0] bref(input logic [509:0] v);
        logic [509:0] q;
        q = v % {255'b0, BP};
        return q[254:0];
    endfunction

    function automatic logic [15:0] sref(input logic [31:0] v);
        logic [31:0] q;
        q = v % 32'd65521;
        return q[15:0];
    endfunction

    task automatic chk(input string nm, input logic [254:0] act, input logic [254:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        chk(nm, {254'b0, act}, {254'b0, exp});
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        chk(nm, 255'(act), 255'(exp));
    endtask

    task automatic wait_b(output int lat);
        lat = 1;
        while (!b_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic big_op(input string nm, input logic [509:0] v, input logic [254:0] e);
        int lat;
        @(negedge clk);
        chk_b({nm, "_rdy"}, b_in_ready, 1'b1);
        b_in_valid = 1;
        b_n = v;
        @(negedge clk);
        b_in_valid = 0;
        wait_b(lat);
        chk_i({nm, "_lat"}, lat, 4);
        chk({nm, "_r"}, b_r, e);
        b_out_ready = 1;
        @(negedge clk);
        b_out_ready = 0;
        chk_b({nm, "_rel"}, b_out_valid, 1'b0);
    endtask

    task automatic small_op(input string nm, input logic [31:0] v, input logic [15:0] e);
        int lat;
        @(negedge clk);
        s_in_valid = 1;
        s_n = v;
        @(negedge clk);
        s_in_valid = 0;
        lat = 1;
        while (!s_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk_i({nm, "_lat"}, lat, 4);
        chk({nm, "_r"}, {239'b0, s_r}, {239'b0, e});
        s_out_ready = 1;
        @(negedge clk);
        s_out_ready = 0;
    endtask

    initial begin
        logic [511:0] t;
        logic [509:0] v, v2;
        logic [15:0] sq[$];
        int lat, done_ops, cyc;
        logic pv;
        logic [31:0] pn;
        rst = 1;
        b_in_valid = 0; b_out_ready = 0; b_n = '0;
        s_in_valid = 0; s_out_ready = 0; s_n = '0;
        repeat (3) @(negedge clk);
        chk_b("rst_b_in_ready", b_in_ready, 1'b1);
        chk_b("rst_b_out_valid", b_out_valid, 1'b0);
        chk("rst_b_r", b_r, '0);
        chk_b("rst_s_out_valid", s_out_valid, 1'b0);
        chk("rst_s_r", {239'b0, s_r}, '0);
        rst = 0;

        t = {16{32'hdeadbeef}};
        v = {t[508:0], 1'b0};
        bt[0] = '{510'd2, 255'd2};
        bt[1] = '{510'd1 << 255, 255'd19};
        bt[2] = '{{255'b0, BP}, 255'd0};
        bt[3] = '{{255'b0, BP - 255'd1}, BP - 255'd1};
        bt[4] = '{510'd0, 255'd0};
        bt[5] = '{{510{1'b1}}, 255'd360};
        bt[6] = '{v, bref(v)};
        for (int i = 0; i < 7; i++) big_op($sformatf("bvec%0d", i), bt[i].n, bt[i].r);

        st[0] = '{32'hFFFFFFFF, 16'd224};
        st[1] = '{32'd65521, 16'd0};
        st[2] = '{32'd65520, 16'd65520};
        st[3] = '{32'd0, 16'd0};
        for (int i = 0; i < 4; i++) small_op($sformatf("svec%0d", i), st[i].n, st[i].r);

        for (int k = 0; k < 30; k++) begin
            v = '0;
            for (int j = 0; j < 16; j++) v = (v << 32) | 510'($urandom);
            big_op("brnd", v, bref(v));
        end

        // backpressure, then same-edge release and accept
        v = {510{1'b1}} - 510'd12345;
        v2 = 510'd77 << 300;
        @(negedge clk);
        b_in_valid = 1; b_n = v;
        @(negedge clk);
        b_in_valid = 0;
        wait_b(lat);
        for (int k = 0; k < 10; k++) begin
            chk("bp_r", b_r, bref(v));
            chk_b("bp_valid", b_out_valid, 1'b1);
            chk_b("bp_in_ready", b_in_ready, 1'b0);
            @(negedge clk);
        end
        b_out_ready = 1; b_in_valid = 1; b_n = v2;
        #1 chk_b("bp_swap_rdy", b_in_ready, 1'b1);
        @(negedge clk);
        b_out_ready = 0; b_in_valid = 0;
        chk_b("bp_swap_drop", b_out_valid, 1'b0);
        wait_b(lat);
        chk_i("bp_swap_lat", lat, 4);
        chk("bp_swap_r", b_r, bref(v2));
        b_out_ready = 1;
        @(negedge clk);
        b_out_ready = 0;

        // new n offered while busy must wait for in_ready
        v = 510'd5 << 400;
        v2 = 510'd123456789;
        @(negedge clk);
        b_in_valid = 1; b_n = v;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            b_in_valid = 1; b_n = v2;
            #1 chk_b("busy_in_ready", b_in_ready, 1'b0);
            @(negedge clk);
        end
        chk_b("busy_valid", b_out_valid, 1'b1);
        chk("busy_r1", b_r, bref(v));
        chk_b("busy_done_rdy", b_in_ready, 1'b0);
        b_out_ready = 1;
        @(negedge clk);
        b_out_ready = 0; b_in_valid = 0;
        wait_b(lat);
        chk_i("busy_lat2", lat, 4);
        chk("busy_r2", b_r, bref(v2));
        b_out_ready = 1;
        @(negedge clk);
        b_out_ready = 0;

        // reset in FOLD2 discards the operation
        @(negedge clk);
        b_in_valid = 1; b_n = 510'd999;
        @(negedge clk);
        b_in_valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk_b("mrst_valid", b_out_valid, 1'b0);
        chk("mrst_r", b_r, '0);
        chk_b("mrst_in_ready", b_in_ready, 1'b1);
        pv = 0;
        repeat (8) begin
            @(negedge clk);
            pv = pv | b_out_valid;
        end
        chk_b("mrst_no_stale", pv, 1'b0);

        // random small-instance traffic with random stalls
        done_ops = 0; cyc = 0; pv = 0; pn = '0;
        while (done_ops < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (pv) sq.push_back(sref(pn));
            s_out_ready = ($urandom_range(3) != 0);
            if (s_out_valid) begin
                chk_b("srnd_pending", sq.size() != 0, 1'b1);
                if (sq.size() != 0) begin
                    chk("srnd_r", {239'b0, s_r}, {239'b0, sq[0]});
                    if (s_out_ready) begin
                        void'(sq.pop_front());
                        done_ops++;
                    end
                end
            end
            s_in_valid = ($urandom_range(1) == 1);
            s_n = $urandom;
            #1;
            pv = s_in_valid && s_in_ready;
            pn = s_n;
        end
        chk_i("srnd_ops", done_ops, 1000);
        s_in_valid = 0;
        s_out_ready = 1;
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
